// File: rtl/rpsc_power_sequencer.sv
// RF power-supply sequencer: G1 then anode start-up, orderly shutdown and latched faults.
// Optional macro RPSC_SEQ_AUTORETRY_EN: FAULT returns to IDLE by itself after 512 ticks.
module rpsc_power_sequencer #(
  parameter int G1_TIMEOUT = 128,
  parameter int AN_TIMEOUT = 256,
  parameter int OFF_DELAY  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       fault_clr,
  input  logic       g1_on_perm,
  input  logic       g1_ok,
  input  logic       an_on_perm,
  input  logic       an_ok,
  output logic       g1_ps_act,
  output logic       an_ps_act,
  output logic       running,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_G1_START = 3'd1,
    S_AN_START = 3'd2,
    S_RUN      = 3'd3,
    S_SHUTDOWN = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  localparam int T_MAX_A = (G1_TIMEOUT > AN_TIMEOUT) ? G1_TIMEOUT : AN_TIMEOUT;
  localparam int T_MAX_B = (T_MAX_A > OFF_DELAY) ? T_MAX_A : OFF_DELAY;
`ifdef RPSC_SEQ_AUTORETRY_EN
  localparam int RETRY_TICKS = 512;
  localparam int T_MAX = (T_MAX_B > RETRY_TICKS) ? T_MAX_B : RETRY_TICKS;
`else
  localparam int T_MAX = T_MAX_B;
`endif
  localparam int TW = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] G1_LAST  = TW'(G1_TIMEOUT - 1);
  localparam logic [TW-1:0] AN_LAST  = TW'(AN_TIMEOUT - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_DELAY - 1);
  localparam logic [TW-1:0] T_SAT    = TW'(T_MAX);
`ifdef RPSC_SEQ_AUTORETRY_EN
  localparam logic [TW-1:0] RETRY_LAST = TW'(RETRY_TICKS - 1);
`endif

  state_t          r_state;
  state_t          w_next;
  logic [TW-1:0]   r_timer;
  logic [2:0]      w_code;
  logic            r_g1_ps_act;
  logic            r_an_ps_act;
  logic            r_running;
  logic            r_fault;
  logic [2:0]      r_fault_code;
  logic            w_perms;

  assign w_perms = g1_on_perm && an_on_perm;

  always_comb begin
    w_next = r_state;
    w_code = 3'd0;
    case (r_state)
      S_IDLE: begin
        if (start && w_perms && !stop) w_next = S_G1_START;
      end
      S_G1_START, S_AN_START, S_RUN, S_SHUTDOWN: begin
        // Fault causes in priority order; the timeouts rank last.
        if (!g1_on_perm)                                              w_code = 3'd3;
        else if (!an_on_perm)                                         w_code = 3'd4;
        else if ((r_state == S_AN_START || r_state == S_RUN) && !g1_ok) w_code = 3'd5;
        else if (r_state == S_RUN && !an_ok)                          w_code = 3'd6;
        else if (r_state == S_G1_START && r_timer == G1_LAST && !g1_ok) w_code = 3'd1;
        else if (r_state == S_AN_START && r_timer == AN_LAST && !an_ok) w_code = 3'd2;

        if (w_code != 3'd0) begin
          w_next = S_FAULT;
        end else if (stop && r_state != S_SHUTDOWN) begin
          w_next = S_SHUTDOWN;
        end else begin
          case (r_state)
            S_G1_START: if (g1_ok) w_next = S_AN_START;
            S_AN_START: if (an_ok) w_next = S_RUN;
            S_SHUTDOWN: if (r_timer == OFF_LAST) w_next = S_IDLE;
            default:    w_next = r_state;
          endcase
        end
      end
      S_FAULT: begin
`ifdef RPSC_SEQ_AUTORETRY_EN
        if (w_perms && (fault_clr || r_timer >= RETRY_LAST)) w_next = S_IDLE;
`else
        if (fault_clr && w_perms) w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_g1_ps_act  <= 1'b0;
      r_an_ps_act  <= 1'b0;
      r_running    <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)    r_timer <= '0;
      else if (r_timer != T_SAT) r_timer <= r_timer + 1'b1;
      r_g1_ps_act <= (w_next inside {S_G1_START, S_AN_START, S_RUN, S_SHUTDOWN});
      r_an_ps_act <= (w_next inside {S_AN_START, S_RUN});
      r_running   <= (w_next == S_RUN);
      r_fault     <= (w_next == S_FAULT);
      if (w_next != S_FAULT)      r_fault_code <= 3'd0;
      else if (r_state != S_FAULT) r_fault_code <= w_code;
    end
  end

  assign g1_ps_act  = r_g1_ps_act;
  assign an_ps_act  = r_an_ps_act;
  assign running    = r_running;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;
  assign state      = r_state;

endmodule

// File: tb/tb_rpsc_power_sequencer.sv
// Bench for rpsc_power_sequencer: directed scenarios then random traffic against a rule-level model.
module tb_rpsc_power_sequencer;

  localparam int G1TO = 8;
  localparam int ANTO = 16;
  localparam int OFFD = 4;
`ifdef RPSC_SEQ_AUTORETRY_EN
  localparam bit AUTORETRY = 1'b1;
`else
  localparam bit AUTORETRY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, stop, fault_clr;
  logic       g1_on_perm, g1_ok, an_on_perm, an_ok;
  logic       g1_ps_act, an_ps_act, running, fault;
  logic [2:0] fault_code, state;

  int checks = 0;
  int errors = 0;

  // Reference model: state number, ticks spent in it, latched cause.
  int m_st, m_t, m_code;

  always #5 clk = ~clk;

  rpsc_power_sequencer #(
    .G1_TIMEOUT(G1TO),
    .AN_TIMEOUT(ANTO),
    .OFF_DELAY (OFFD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .fault_clr (fault_clr),
    .g1_on_perm(g1_on_perm),
    .g1_ok     (g1_ok),
    .an_on_perm(an_on_perm),
    .an_ok     (an_ok),
    .g1_ps_act (g1_ps_act),
    .an_ps_act (an_ps_act),
    .running   (running),
    .fault     (fault),
    .fault_code(fault_code),
    .state     (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_t = 0; m_code = 0;
  endtask

  // Next state from the rule list: ranked fault causes, then stop, then progress.
  task automatic model_step();
    int  nx, cause;
    int  prio[6];
    bit  hit[1:6];
    bit  perms;
    prio  = '{3, 4, 5, 6, 1, 2};
    perms = g1_on_perm && an_on_perm;
    nx    = m_st;
    cause = 0;
    for (int k = 1; k <= 6; k++) hit[k] = 1'b0;
    if (m_st == 0) begin
      if (start && perms && !stop) nx = 1;
    end else if (m_st == 5) begin
      if (perms && (fault_clr || (AUTORETRY && m_t >= 511))) nx = 0;
    end else begin
      hit[3] = !g1_on_perm;
      hit[4] = !an_on_perm;
      hit[5] = (m_st == 2 || m_st == 3) && !g1_ok;
      hit[6] = (m_st == 3) && !an_ok;
      hit[1] = (m_st == 1) && !g1_ok && (m_t == G1TO - 1);
      hit[2] = (m_st == 2) && !an_ok && (m_t == ANTO - 1);
      for (int k = 0; k < 6; k++) if (cause == 0 && hit[prio[k]]) cause = prio[k];
      if (cause != 0)                  nx = 5;
      else if (stop && m_st != 4)      nx = 4;
      else if (m_st == 1 && g1_ok)     nx = 2;
      else if (m_st == 2 && an_ok)     nx = 3;
      else if (m_st == 4 && m_t == OFFD - 1) nx = 0;
    end
    if (nx == 5 && m_st != 5) m_code = cause;
    else if (nx != 5)         m_code = 0;
    if (nx != m_st) m_t = 0;
    else            m_t++;
    m_st = nx;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, ".state"},   32'(state),      32'(m_st));
    chk({ph, ".g1_act"},  32'(g1_ps_act),  32'(m_st >= 1 && m_st <= 4));
    chk({ph, ".an_act"},  32'(an_ps_act),  32'(m_st == 2 || m_st == 3));
    chk({ph, ".running"}, 32'(running),    32'(m_st == 3));
    chk({ph, ".fault"},   32'(fault),      32'(m_st == 5));
    chk({ph, ".code"},    32'(fault_code), 32'(m_code));
  endtask

  task automatic tick(input string ph);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(ph);
  endtask

  task automatic set_in(input logic s, input logic p, input logic c,
                        input logic gp, input logic go, input logic ap, input logic ao);
    start = s; stop = p; fault_clr = c;
    g1_on_perm = gp; g1_ok = go; an_on_perm = ap; an_ok = ao;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    #2 reset = 1'b0;
    #1;
    chk("post_reset_no_early_move", 32'(state), 32'd0);

    // Start-up: g1_ok on the 3rd sample of G1_START, an_ok on the 5th of AN_START.
    tick("st_enter");
    chk("st_in_g1", 32'(state), 32'd1);
    start = 1'b0;
    repeat (2) tick("st_g1wait");
    g1_ok = 1'b1;
    tick("st_g1ok");
    chk("st_in_an", 32'(state), 32'd2);
    repeat (4) tick("st_anwait");
    an_ok = 1'b1;
    tick("st_anok");
    chk("run_state", 32'(state), 32'd3);
    chk("run_running", 32'(running), 32'd1);
    chk("run_both_act", 32'({g1_ps_act, an_ps_act}), 32'd3);

    // Orderly stop.
    stop = 1'b1;
    tick("stop0");
    chk("stop_an_off", 32'(an_ps_act), 32'd0);
    chk("stop_g1_held", 32'(g1_ps_act), 32'd1);
    stop = 1'b0;
    repeat (3) tick("stop_hold");
    chk("stop_g1_still", 32'(g1_ps_act), 32'd1);
    tick("stop_end");
    chk("stop_g1_off", 32'(g1_ps_act), 32'd0);
    chk("stop_idle", 32'(state), 32'd0);

    // G1 timeout.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick("g1to_enter");
    start = 1'b0;
    cnt = 0;
    while (state != 3'd5 && cnt < 20) begin
      tick("g1to_wait");
      cnt++;
    end
    chk("g1to_ticks", 32'(cnt), 32'd8);
    chk("g1to_code", 32'(fault_code), 32'd1);
    chk("g1to_g1_off", 32'(g1_ps_act), 32'd0);
    fault_clr = 1'b1;
    tick("g1to_clr");
    chk("g1to_cleared", 32'(state), 32'd0);
    fault_clr = 1'b0;

    // Simultaneous g1_on_perm loss and an_ok loss in RUN.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) tick("pri_climb");
    start = 1'b0;
    chk("pri_in_run", 32'(state), 32'd3);
    g1_on_perm = 1'b0; an_ok = 1'b0;
    tick("pri_fault");
    chk("pri_code3", 32'(fault_code), 32'd3);
    an_ok = 1'b1; fault_clr = 1'b1;
    tick("pri_clr_noperm");
    chk("pri_stays_fault", 32'(state), 32'd5);
    chk("pri_code_held", 32'(fault_code), 32'd3);
    g1_on_perm = 1'b1;
    tick("pri_clr_ok");
    chk("pri_exit", 32'(state), 32'd0);
    chk("pri_code_zero", 32'(fault_code), 32'd0);
    fault_clr = 1'b0;

    // Asynchronous reset in the middle of AN_START.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) tick("ar_climb");
    chk("ar_in_an", 32'(state), 32'd2);
    start = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_acts", 32'({g1_ps_act, an_ps_act, running, fault}), 32'd0);
    chk("ar_code", 32'(fault_code), 32'd0);
    model_reset();
    #2 reset = 1'b0;
    tick("ar_after");

    // Anode timeout, then long wait without fault_clr.
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick("an_enter");
    start = 1'b0;
    cnt = 0;
    while (state != 3'd5 && cnt < 40) begin
      tick("an_wait");
      cnt++;
    end
    chk("an_code2", 32'(fault_code), 32'd2);
    repeat (600) tick("retry_wait");
    chk("retry_final", 32'(state), AUTORETRY ? 32'd0 : 32'd5);
    fault_clr = 1'b1;
    tick("retry_clr");
    fault_clr = 1'b0;

    // Random traffic with sticky supply/permission levels.
    for (int i = 0; i < 4000; i++) begin
      start     = ($urandom_range(0, 99) < 25);
      stop      = ($urandom_range(0, 99) < 3);
      fault_clr = ($urandom_range(0, 99) < 10);
      g1_on_perm = g1_on_perm ? ($urandom_range(0, 199) != 0) : ($urandom_range(0, 3) == 0);
      an_on_perm = an_on_perm ? ($urandom_range(0, 199) != 0) : ($urandom_range(0, 3) == 0);
      g1_ok = g1_ok ? ($urandom_range(0, 99) < 97) : ($urandom_range(0, 99) < 30);
      an_ok = an_ok ? ($urandom_range(0, 99) < 97) : ($urandom_range(0, 99) < 30);
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rpsc_power_sequencer.md
RPSC_POWER_SEQUENCER -- requirements
Module: rpsc_power_sequencer

Interface
REQ-001 Parameter G1_TIMEOUT, default 128, is the number of clk ticks allowed for g1_ok after g1_ps_act asserts (2 s at 64 Hz).
REQ-002 Parameter AN_TIMEOUT, default 256, is the number of clk ticks allowed for an_ok after an_ps_act asserts (4 s at 64 Hz).
REQ-003 Parameter OFF_DELAY, default 64, is the number of ticks g1_ps_act is held after an_ps_act drops during orderly shutdown.
REQ-004 clk  in  1  single system clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  operator start request, level-sampled each clk.
REQ-007 stop  in  1  operator stop request, level-sampled each clk.
REQ-008 fault_clr  in  1  clears a latched fault.
REQ-009 g1_on_perm  in  1  G1 interlock chain healthy (1 = permitted).
REQ-010 g1_ok  in  1  G1 supply confirmed OK (2 s check already applied upstream).
REQ-011 an_on_perm  in  1  anode interlock chain healthy (1 = permitted).
REQ-012 an_ok  in  1  anode supply confirmed OK.
REQ-013 g1_ps_act  out  1  G1 supply activate command.
REQ-014 an_ps_act  out  1  anode supply activate command.
REQ-015 running  out  1  high only in state RUN.
REQ-016 fault  out  1  high only in state FAULT.
REQ-017 fault_code  out  3  cause of the latched fault (see REQ-027).
REQ-018 state  out  3  encoding: IDLE=0, G1_START=1, AN_START=2, RUN=3, SHUTDOWN=4, FAULT=5.

Function
REQ-019 The FSM, timer and all outputs SHALL be registered, and every output SHALL change exactly one clk after the triggering input is sampled.
REQ-020 IDLE: outputs are low; start=1 & g1_on_perm=1 & an_on_perm=1 & stop=0 SHALL transition to G1_START; start while any permission is low SHALL be ignored and SHALL NOT fault.
REQ-021 G1_START: g1_ps_act=1 and the timer counts from 0; g1_ok=1 SHALL transition to AN_START with the timer cleared; the timer reaching G1_TIMEOUT-1 without g1_ok SHALL transition to FAULT with code 1.
REQ-022 AN_START: g1_ps_act=1 and an_ps_act=1; an_ok=1 SHALL transition to RUN; the timer reaching AN_TIMEOUT-1 without an_ok SHALL transition to FAULT with code 2.
REQ-023 RUN: both activate commands SHALL be high and running=1.
REQ-024 stop=1 in G1_START, AN_START or RUN SHALL transition to SHUTDOWN: an_ps_act=0 immediately, g1_ps_act held for OFF_DELAY ticks, then IDLE.
REQ-025 SHUTDOWN SHALL ignore start, g1_ok and an_ok; loss of a permission during SHUTDOWN SHALL go to FAULT.
REQ-026 In every non-IDLE, non-FAULT state, fault checks SHALL take priority over stop, and stop SHALL take priority over progress transitions.
REQ-027 Fault priority on simultaneous causes SHALL be: 3 = g1_on_perm lost, 4 = an_on_perm lost, 5 = g1_ok lost in AN_START/RUN, 6 = an_ok lost in RUN, then the timeout codes 1/2.
REQ-028 FAULT SHALL drive both activate commands low in the same cycle it is entered, and fault_code SHALL hold until the state leaves FAULT.
REQ-029 fault_code SHALL be 0 in every state other than FAULT.
REQ-030 The timer SHALL saturate and never wrap; its width SHALL be clog2 of max(G1_TIMEOUT, AN_TIMEOUT, OFF_DELAY)+1.
REQ-031 fault_clr SHALL be ignored outside FAULT.

Reset
REQ-032 Asserting reset SHALL, asynchronously and at any time including mid-sequence, force state IDLE, clear the timer, and drive g1_ps_act, an_ps_act, running, fault and fault_code to 0.
REQ-033 The first transition after reset deasserts SHALL occur no earlier than the first rising clk edge following deassertion.

Configuration
REQ-034 When macro RPSC_SEQ_AUTORETRY_EN is defined, FAULT SHALL wait 512 ticks, then return to IDLE provided both permissions are high; fault_clr SHALL still exit immediately.
REQ-035 When RPSC_SEQ_AUTORETRY_EN is undefined, FAULT SHALL exit to IDLE only on fault_clr=1 with g1_on_perm=1 and an_on_perm=1.

Verification (G1_TIMEOUT=8, AN_TIMEOUT=16, OFF_DELAY=4)
REQ-036 Start with permissions high; g1_ok at tick 3, an_ok at tick 5 of AN_START -> state 1->2->3, running=1, both activate commands high.
REQ-037 Start with g1_ok held low -> FAULT entered 8 ticks after g1_ps_act rises, fault_code=1, g1_ps_act=0.
REQ-038 In RUN, assert stop -> an_ps_act=0 next clk, g1_ps_act=0 exactly 4 ticks later, state=0.
REQ-039 In RUN, drop g1_on_perm and an_ok in the same cycle -> FAULT with fault_code=3; fault_clr while g1_on_perm=0 -> remains in FAULT.
REQ-040 Assert reset asynchronously mid-AN_START -> all outputs 0 before the next clk edge; state=0.
REQ-041 With RPSC_SEQ_AUTORETRY_EN defined, force code 2 -> IDLE after 512 ticks with no fault_clr; with the macro undefined -> still FAULT at tick 600.
